// File: rtl/hard_mem_1rw_d256_w95_req_ctrl.sv
// hard_mem_1rw_d256_w95_req_ctrl: request controller for the 1rw 256x95 SRAM with post-reset
// zero-fill and a credit-managed read-response FIFO
module hard_mem_1rw_d256_w95_req_ctrl #(
  parameter int width_p = 95,
  parameter int els_p = 256,
  parameter int addr_width_lp = $clog2(els_p),
  parameter int resp_els_p = 3,
  parameter bit clear_on_reset_p = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     req_v_i,
  input  logic                     req_w_i,
  input  logic [addr_width_lp-1:0] req_addr_i,
  input  logic [width_p-1:0]       req_data_i,
  output logic                     req_ready_o,
  output logic                     resp_v_o,
  output logic [width_p-1:0]       resp_data_o,
  input  logic                     resp_yumi_i,
  output logic                     init_done_o,
  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  input  logic [width_p-1:0]       mem_data_i
);
  localparam int ptr_w_lp = (resp_els_p > 1) ? $clog2(resp_els_p) : 1;
  localparam int cnt_w_lp = $clog2(resp_els_p + 1);
  localparam int crd_w_lp = cnt_w_lp + 1;
  typedef enum logic [1:0] {RST, CLEAR, RUN} state_e;
  state_e state_r, state_n;
  logic [addr_width_lp-1:0] clr_cnt;
  logic rd_inflight_r;
  logic [width_p-1:0] fifo_r [resp_els_p];
  logic [ptr_w_lp-1:0] wptr_r, rptr_r;
  logic [cnt_w_lp-1:0] fifo_count;
  logic [crd_w_lp-1:0] credits;
  logic push, pop, rd_accept;
  // Credits count both the read in flight and buffered responses, so the FIFO can never overflow
  assign credits = crd_w_lp'(rd_inflight_r) + crd_w_lp'(fifo_count);
  assign push = rd_inflight_r;
  assign pop = resp_yumi_i & resp_v_o;
  assign rd_accept = req_v_i & req_ready_o & ~req_w_i;
  assign resp_v_o = fifo_count != '0;
  assign resp_data_o = fifo_r[rptr_r];
  always_comb begin
    state_n = state_r;
    req_ready_o = 1'b0;
    init_done_o = 1'b0;
    mem_v_o = 1'b0;
    mem_w_o = 1'b0;
    mem_addr_o = req_addr_i;
    mem_data_o = req_data_i;
    case (state_r)
      RST: state_n = clear_on_reset_p ? CLEAR : RUN;
      CLEAR: begin
        mem_v_o = 1'b1;
        mem_w_o = 1'b1;
        mem_addr_o = clr_cnt;
        mem_data_o = '0;
        state_n = (clr_cnt == addr_width_lp'(els_p - 1)) ? RUN : CLEAR;
      end
      RUN: begin
        init_done_o = 1'b1;
        req_ready_o = credits < crd_w_lp'(resp_els_p);
        mem_v_o = req_v_i & req_ready_o;
        mem_w_o = req_w_i;
      end
      default: state_n = RST;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_r <= RST;
      clr_cnt <= '0;
      rd_inflight_r <= 1'b0;
      wptr_r <= '0;
      rptr_r <= '0;
      fifo_count <= '0;
    end else begin
      state_r <= state_n;
      clr_cnt <= (state_r == CLEAR) ? clr_cnt + 1'b1 : clr_cnt;
      rd_inflight_r <= rd_accept;
      wptr_r <= !push ? wptr_r : (wptr_r == ptr_w_lp'(resp_els_p - 1)) ? '0 : wptr_r + 1'b1;
      rptr_r <= !pop ? rptr_r : (rptr_r == ptr_w_lp'(resp_els_p - 1)) ? '0 : rptr_r + 1'b1;
      fifo_count <= fifo_count + cnt_w_lp'(push) - cnt_w_lp'(pop);
    end
  // Capture in the cycle after issue, before any following write can change the SRAM's held output
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) for (int i = 0; i < resp_els_p; i++) fifo_r[i] <= '0;
    else if (push) fifo_r[wptr_r] <= mem_data_i;
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(push && !pop && fifo_count == cnt_w_lp'(resp_els_p)));
  a_yumi_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    resp_yumi_i |-> resp_v_o);
endmodule
